// File: rtl/mem_io_bridge_if.sv
// Core-side byte bus between the cpu and the memory/IO bridge.
// The core drives address/data/direction; the bridge returns read data and rdy.
interface mem_io_bridge_if;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;

  modport master (
    output cpu_a, cpu_dout, cpu_wr,
    input  cpu_din, cpu_rdy
  );

  modport slave (
    input  cpu_a, cpu_dout, cpu_wr,
    output cpu_din, cpu_rdy
  );
endinterface

// File: rtl/mem_io_bridge.sv
// Memory/IO bridge: decodes core accesses to RAM or the I/O page (uart rx/tx,
// cycle counter, program-stop flag) and stalls the core while the tx FIFO is full.
module mem_io_bridge #(
  parameter int TX_DEPTH_LOG2 = 3,
  parameter int RAM_ADDR_W    = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_io_bridge_if.slave        cpu,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_pop,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  program_finish
);

  typedef enum logic [1:0] {
    SRC_RAM,
    SRC_RX,
    SRC_CNT,
    SRC_ZERO
  } rdSrcT;

  localparam int Depth = 1 << TX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] FullCount = (TX_DEPTH_LOG2 + 1)'(Depth);

  logic isIo;
  logic hitData;
  logic hitCnt;
  logic rdAccept;
  logic wrAccept;
  logic stopWrite;
  logic latchCnt;
  logic txPush;
  logic txPop;
  logic txFull;
  logic [7:0] pushByte;
  logic unusedAddrBits;

  rdSrcT rdSrc;
  rdSrcT nextSrc;
  logic [1:0]  rdLane;
  logic [7:0]  rxByte;
  logic [31:0] snapshot;
  logic [31:0] cycleCount;
  logic        finishFlag;

  logic [7:0]               txMem [Depth];
  logic [TX_DEPTH_LOG2-1:0] wrPtr;
  logic [TX_DEPTH_LOG2-1:0] rdPtr;
  logic [TX_DEPTH_LOG2:0]   txCount;

  // Only address bits [17:0] take part in decoding.
  assign unusedAddrBits = ^cpu.cpu_a[31:18];

  assign isIo     = (cpu.cpu_a[17:16] == 2'b11);
  assign hitData  = isIo && (cpu.cpu_a[15:0] == 16'h0000);
  assign hitCnt   = isIo && (cpu.cpu_a[15:2] == 14'h0001);
  assign txFull   = (txCount == FullCount);

  assign cpu.cpu_rdy = !rst && !txFull;
  assign rdAccept    = cpu.cpu_rdy && !cpu.cpu_wr;
  assign wrAccept    = cpu.cpu_rdy && cpu.cpu_wr;

  assign stopWrite = wrAccept && hitCnt && (cpu.cpu_a[1:0] == 2'b00);
  assign latchCnt  = rdAccept && hitCnt && (cpu.cpu_a[1:0] == 2'b00);
  assign txPush    = (wrAccept && hitData && (cpu.cpu_dout != 8'h00)) || stopWrite;
  assign pushByte  = stopWrite ? 8'h00 : cpu.cpu_dout;
  assign txPop     = tx_valid && tx_ready;

  assign ram_a     = cpu.cpu_a[RAM_ADDR_W-1:0];
  assign ram_wdata = cpu.cpu_dout;
  assign ram_we    = cpu.cpu_wr && !isIo && cpu.cpu_rdy;

  assign rx_pop         = rdAccept && hitData && rx_valid;
  assign tx_valid       = (txCount != '0);
  assign tx_data        = txMem[rdPtr];
  assign program_finish = finishFlag;

  // Writes and reads of unmapped I/O fall through to the zero source.
  always_comb begin
    nextSrc = SRC_ZERO;
    if (rdAccept) begin
      if (!isIo) begin
        nextSrc = SRC_RAM;
      end else if (hitData && rx_valid) begin
        nextSrc = SRC_RX;
      end else if (hitCnt) begin
        nextSrc = SRC_CNT;
      end
    end
  end

  always_comb begin
    cpu.cpu_din = 8'h00;
    case (rdSrc)
      SRC_RAM: cpu.cpu_din = ram_rdata;
      SRC_RX:  cpu.cpu_din = rxByte;
      SRC_CNT: begin
        case (rdLane)
          2'd0:    cpu.cpu_din = snapshot[7:0];
          2'd1:    cpu.cpu_din = snapshot[15:8];
          2'd2:    cpu.cpu_din = snapshot[23:16];
          default: cpu.cpu_din = snapshot[31:24];
        endcase
      end
      default: cpu.cpu_din = 8'h00;
    endcase
  end

  // Read source is held while the core is frozen so its pending result stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdSrc    <= SRC_ZERO;
      rdLane   <= 2'd0;
      rxByte   <= 8'h00;
      snapshot <= 32'h0;
    end else if (cpu.cpu_rdy) begin
      rdSrc  <= nextSrc;
      rdLane <= cpu.cpu_a[1:0];
      if (rx_pop) begin
        rxByte <= rx_data;
      end
      if (latchCnt) begin
        snapshot <= cycleCount;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycleCount <= 32'h0;
      finishFlag <= 1'b0;
    end else begin
      cycleCount <= cycleCount + 32'd1;
      if (stopWrite) begin
        finishFlag <= 1'b1;
      end
    end
  end

  // Storage is cleared too, so tx_data reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      txCount <= '0;
      for (int i = 0; i < Depth; i++) begin
        txMem[i] <= 8'h00;
      end
    end else begin
      if (txPush) begin
        txMem[wrPtr] <= pushByte;
        wrPtr        <= wrPtr + 1'b1;
      end
      if (txPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({txPush, txPop})
        2'b10:   txCount <= txCount + 1'b1;
        2'b01:   txCount <= txCount - 1'b1;
        default: txCount <= txCount;
      endcase
    end
  end

endmodule
